pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage core. It merges stall requests from IF, ID, EX and MEM into the 6-bit `stall` vector consumed by every pipeline register, including MEM/WB. It turns exceptions reported at MEM into a one-cycle `flush` plus exception-vector `new_pc`, and blocks re-triggering in the cycle after a flush. It also runs a bus-stall watchdog and a saturating stall-cycle performance counter.

---
 rtl/pipe_ctrl.sv | 121 ++++++++++++
 tb/tb_pipe_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller for the five-stage core.
//   Merges stall requests into the per-stage stall vector. Converts MEM
//   exceptions into a one-cycle flush and an exception-vector PC. Runs a
//   bus-stall watchdog and a saturating stall-cycle counter.
// Ports:
//   clk, rst (async, active-low)
//   stallreq_if/id/ex/mem  stall requests from each stage
//   excepttype_i           MEM exception code, 0 = none
//   cp0_epc_i              forwarded CP0 EPC (eret target)
//   cnt_clr                synchronous clear of stall_cnt
//   stall[5:0]             PC, IF, ID, EX, MEM, WB hold bits
//   flush, new_pc          pipeline flush and redirect target
//   bus_timeout            one-cycle watchdog pulse (registered)
//   stall_cnt              stall-cycle count (registered, saturating)
module pipe_ctrl #(
  parameter logic [31:0] EBASE       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        cnt_clr,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        bus_timeout,
  output logic [31:0] stall_cnt
);

  localparam int unsigned     WD_W    = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  typedef enum logic {
    RUN,
    POSTFLUSH
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [WD_W-1:0] wd;
  logic            bus_req;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: any exception seen in RUN flushes; the following
  // cycle ignores the exception input.
  always_comb begin
    state_next = state;
    unique case (state)
      RUN:       if (excepttype_i != '0) state_next = POSTFLUSH;
      POSTFLUSH: state_next = RUN;
      default:   state_next = RUN;
    endcase
  end

  // Output logic: flush overrides every stall request.
  always_comb begin
    flush  = 1'b0;
    new_pc = '0;
    stall  = '0;
    if (rst) begin
      if (state == RUN && excepttype_i != '0) begin
        flush = 1'b1;
        unique case (excepttype_i)
          32'h0000_0001: new_pc = EBASE + 32'h20;
          32'h0000_000e: new_pc = cp0_epc_i;
          default:       new_pc = EBASE + 32'h40;
        endcase
      end else if (stallreq_mem) begin
        stall = 6'b011111;
      end else if (stallreq_ex) begin
        stall = 6'b001111;
      end else if (stallreq_id || stallreq_if) begin
        stall = 6'b000111;
      end
    end
  end

  assign bus_req = stallreq_if | stallreq_mem;

  // Watchdog: wraps at TIMEOUT_CYC so a persistent stall pulses periodically.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd          <= '0;
      bus_timeout <= 1'b0;
    end else if (flush || !bus_req) begin
      wd          <= '0;
      bus_timeout <= 1'b0;
    end else if (wd == WD_LAST) begin
      wd          <= '0;
      bus_timeout <= 1'b1;
    end else begin
      wd          <= wd + WD_W'(1);
      bus_timeout <= 1'b0;
    end
  end

  // Stall-cycle counter; clear has priority over increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (stall[0] && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl with TIMEOUT_CYC=4 and EBASE=0.
module tb_pipe_ctrl;

  localparam int unsigned T  = 4;
  localparam logic [31:0] EB = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic [31:0] excepttype_i, cp0_epc_i;
  logic        cnt_clr;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        bus_timeout;
  logic [31:0] stall_cnt;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Model of registered behaviour
  bit          m_flushed_last = 1'b0;
  int unsigned m_run = 0;
  logic        m_to = 1'b0;
  logic [31:0] m_cnt = '0;

  always #5 clk = ~clk;

  pipe_ctrl #(.EBASE(EB), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .excepttype_i(excepttype_i), .cp0_epc_i(cp0_epc_i), .cnt_clr(cnt_clr),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .bus_timeout(bus_timeout), .stall_cnt(stall_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, at negedge while inputs are stable.
  initial begin : compare
    logic        e_flush;
    logic [31:0] e_pc;
    logic [5:0]  e_stall;
    forever begin
      @(negedge clk);
      e_flush = 1'b0;
      e_pc    = '0;
      e_stall = '0;
      if (rst === 1'b1) begin
        e_flush = !m_flushed_last && (excepttype_i != 0);
        if (e_flush) begin
          if (excepttype_i == 32'h1)      e_pc = EB + 32'h20;
          else if (excepttype_i == 32'he) e_pc = cp0_epc_i;
          else                            e_pc = EB + 32'h40;
        end else if (stallreq_mem) e_stall = 6'h1f;
        else if (stallreq_ex)      e_stall = 6'h0f;
        else if (stallreq_id || stallreq_if) e_stall = 6'h07;
        chk("m_stall", 32'(stall), 32'(e_stall));
        chk("m_flush", 32'(flush), 32'(e_flush));
        chk("m_new_pc", new_pc, e_pc);
        chk("m_bus_timeout", 32'(bus_timeout), 32'(m_to));
        chk("m_stall_cnt", stall_cnt, m_cnt);
        // advance model to the next posedge
        m_flushed_last = e_flush;
        if (!e_flush && (stallreq_if || stallreq_mem)) begin
          m_run++;
          m_to = (m_run % T) == 0;
        end else begin
          m_run = 0;
          m_to  = 1'b0;
        end
        if (cnt_clr) m_cnt = '0;
        else if (e_stall[0] && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
      end else begin
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_new_pc", new_pc, 32'h0);
        chk("rst_bus_timeout", 32'(bus_timeout), 32'h0);
        chk("rst_stall_cnt", stall_cnt, 32'h0);
        m_flushed_last = 1'b0;
        m_run = 0;
        m_to  = 1'b0;
        m_cnt = '0;
      end
    end
  end

  task automatic set_in(input logic i_if, input logic i_id, input logic i_ex,
                        input logic i_mem, input logic [31:0] exc,
                        input logic [31:0] epc, input logic clr);
    @(posedge clk);
    #1;
    stallreq_if  = i_if;
    stallreq_id  = i_id;
    stallreq_ex  = i_ex;
    stallreq_mem = i_mem;
    excepttype_i = exc;
    cp0_epc_i    = epc;
    cnt_clr      = clr;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin : stimulus
    rst = 1'b0;
    stallreq_if = 1'b0; stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0;
    excepttype_i = '0; cp0_epc_i = '0; cnt_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #2;
    chk("reset_cnt", stall_cnt, 32'h0);
    chk("reset_stall", 32'(stall), 32'h0);

    // Stall priority
    set_in(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0); #2;
    chk("prio_id", 32'(stall), 32'h07);
    set_in(1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h0, 1'b0); #2;
    chk("prio_ex", 32'(stall), 32'h0f);
    set_in(1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0, 1'b0); #2;
    chk("prio_mem", 32'(stall), 32'h1f);
    idle(); #2;
    chk("prio_none", 32'(stall), 32'h00);
    chk("prio_cnt", stall_cnt, 32'd3);

    // Exception decode
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h1, 32'h0, 1'b0); #2;
    chk("exc1_flush", 32'(flush), 32'h1);
    chk("exc1_pc", new_pc, 32'h20);
    chk("exc1_stall", 32'(stall), 32'h0);
    idle();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'hc, 32'h0, 1'b0); #2;
    chk("excc_pc", new_pc, 32'h40);
    idle();
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'he, 32'hBFC0_0100, 1'b0); #2;
    chk("exce_pc", new_pc, 32'hBFC0_0100);
    idle();

    // Held exception: flush, ignored, flush
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0, 1'b0); #2;
    chk("pf_flush0", 32'(flush), 32'h1);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0, 1'b0); #2;
    chk("pf_flush1", 32'(flush), 32'h0);
    set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h8, 32'h0, 1'b0); #2;
    chk("pf_flush2", 32'(flush), 32'h1);
    idle();

    // Watchdog: pulses visible in cycles 5 and 9 of a 10-cycle stall
    for (int k = 1; k <= 10; k++) begin
      set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0); #2;
      chk($sformatf("wd_cyc%0d", k), 32'(bus_timeout), (k == 5 || k == 9) ? 32'h1 : 32'h0);
    end
    idle(); #2;
    chk("wd_after", 32'(bus_timeout), 32'h0);
    chk("wd_cnt", stall_cnt, 32'd13);

    // Flush beats stall
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'ha, 32'h0, 1'b0); #2;
    chk("fvs_stall", 32'(stall), 32'h0);
    chk("fvs_flush", 32'(flush), 32'h1);
    chk("fvs_pc", new_pc, 32'h40);
    idle(); #2;
    chk("fvs_cnt", stall_cnt, 32'd13);

    // Clear wins over increment
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1);
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0); #2;
    chk("clr_cnt", stall_cnt, 32'd0);
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0); #2;
    chk("clr_cnt_next", stall_cnt, 32'd1);

    // Asynchronous reset mid-stall, with an exception pending
    @(posedge clk);
    #1;
    excepttype_i = 32'h1;
    rst = 1'b0;
    #1;
    chk("arst_stall", 32'(stall), 32'h0);
    chk("arst_flush", 32'(flush), 32'h0);
    chk("arst_pc", new_pc, 32'h0);
    chk("arst_cnt", stall_cnt, 32'h0);
    chk("arst_to", 32'(bus_timeout), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    excepttype_i = 32'h0;
    set_in(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 1'b0); #2;
    chk("rel_cnt", stall_cnt, 32'd1);
    idle();
    idle();
    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
